// File: rtl/minisys_pkg.sv
// Shared definitions for the Minisys core front end: fetch FSM states and
// the instruction encodings the fetch/decode boundary cares about.
package minisys_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec
    } fetch_state_e;

    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] FunctJr = 6'h08;

    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/minisys_npc.sv
// Combinational next-PC select: jr, then j/jal, then taken branch, else
// sequential. The result is always word aligned.
module minisys_npc (
    input  logic [31:0] pc_plus_4_i,
    input  logic [25:0] instr_index_i,
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        jmp_i,
    input  logic        jal_i,
    input  logic        jrn_i,
    input  logic        zero_i,
    input  logic [31:0] add_result_i,
    input  logic [31:0] read_data_1_i,
    output logic [31:0] npc_o
);

    logic        taken;
    logic [31:0] raw_npc;

    assign taken = (branch_i & zero_i) | (nbranch_i & ~zero_i);

    always_comb begin
        raw_npc = pc_plus_4_i;
        if (jrn_i) begin
            raw_npc = read_data_1_i;
        end else if (jmp_i || jal_i) begin
            raw_npc = {pc_plus_4_i[31:28], instr_index_i, 2'b00};
        end else if (taken) begin
            raw_npc = add_result_i;
        end
    end

    assign npc_o = {raw_npc[31:2], 2'b00};

endmodule

// File: rtl/minisys_ifetch.sv
// Minisys instruction-fetch stage: PC register, req/ack fetch FSM and the
// registered instruction presented to control and decode.
module minisys_ifetch
    import minisys_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jrn,
    input  logic               Zero,
    input  logic [31:0]        Add_result,
    input  logic [31:0]        Read_data_1,
    output logic [31:0]        Instruction,
    output logic [5:0]         Opcode,
    output logic [5:0]         Function_opcode,
    output logic               instr_valid,
    output logic [31:0]        PC,
    output logic [31:0]        PC_plus_4,
    output logic [31:0]        link_addr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  link_q, link_d;
    logic [31:0]  npc;
    logic [31:0]  pc_plus_4;

    assign pc_plus_4 = pc_q + 32'd4;

    minisys_npc u_npc (
        .pc_plus_4_i   (pc_plus_4),
        .instr_index_i (instr_q[25:0]),
        .branch_i      (Branch),
        .nbranch_i     (nBranch),
        .jmp_i         (Jmp),
        .jal_i         (Jal),
        .jrn_i         (Jrn),
        .zero_i        (Zero),
        .add_result_i  (Add_result),
        .read_data_1_i (Read_data_1),
        .npc_o         (npc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        link_d      = link_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                // Control and execute results are only consumed on the commit edge.
                if (!stall) begin
                    pc_d    = npc;
                    state_d = StFetch;
                    if (Jal) begin
                        link_d = pc_plus_4;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            link_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            link_q  <= link_d;
        end
    end

    assign imem_addr       = pc_q[IMEM_AW+1:2];
    assign Instruction     = instr_q;
    assign Opcode          = instr_q[31:26];
    assign Function_opcode = instr_q[5:0];
    assign PC              = pc_q;
    assign PC_plus_4       = pc_plus_4;
    assign link_addr       = link_q;

endmodule

// File: tb/tb_minisys_ifetch.sv
// Directed self-checking bench for minisys_ifetch: sequential fetch, wait
// states, branches, jal/jr, stall, PC wrap and asynchronous reset mid-fetch.
module tb_minisys_ifetch;
    import minisys_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Branch, nBranch, Jmp, Jal, Jrn, Zero;
    logic [31:0] Add_result, Read_data_1;
    logic [31:0] Instruction;
    logic [5:0]  Opcode, Function_opcode;
    logic        instr_valid;
    logic [31:0] PC, PC_plus_4, link_addr;

    int n_checks = 0;
    int n_pass   = 0;

    minisys_ifetch dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .Branch          (Branch),
        .nBranch         (nBranch),
        .Jmp             (Jmp),
        .Jal             (Jal),
        .Jrn             (Jrn),
        .Zero            (Zero),
        .Add_result      (Add_result),
        .Read_data_1     (Read_data_1),
        .Instruction     (Instruction),
        .Opcode          (Opcode),
        .Function_opcode (Function_opcode),
        .instr_valid     (instr_valid),
        .PC              (PC),
        .PC_plus_4       (PC_plus_4),
        .link_addr       (link_addr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick;
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req"},   {31'b0, imem_req}, 32'd0);
        check({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, ".pc"},    PC, 32'h0);
        check({tag, ".pc4"},   PC_plus_4, 32'h4);
        check({tag, ".instr"}, Instruction, 32'h0);
        check({tag, ".link"},  link_addr, 32'h0);
        check({tag, ".addr"},  {18'b0, imem_addr}, 32'h0);
        check({tag, ".op"},    {26'b0, Opcode}, 32'h0);
        check({tag, ".fn"},    {26'b0, Function_opcode}, 32'h0);
    endtask

    // Serve one fetch at exp_pc with `waits` idle cycles before the ack;
    // ends in EXEC with the word checked.
    task automatic fetch(input int waits, input logic [31:0] word, input logic [31:0] exp_pc);
        check("fetch.req", {31'b0, imem_req}, 32'd1);
        check("fetch.addr", {18'b0, imem_addr}, {18'b0, exp_pc[15:2]});
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            tick();
            check("wait.req", {31'b0, imem_req}, 32'd1);
            check("wait.addr", {18'b0, imem_addr}, {18'b0, exp_pc[15:2]});
            check("wait.valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        check("exec.valid", {31'b0, instr_valid}, 32'd1);
        check("exec.req", {31'b0, imem_req}, 32'd0);
        check("exec.instr", Instruction, word);
        check("exec.op", {26'b0, Opcode}, {26'b0, word[31:26]});
        check("exec.fn", {26'b0, Function_opcode}, {26'b0, word[5:0]});
        check("exec.pc", PC, exp_pc);
        check("exec.pc4", PC_plus_4, exp_pc + 32'd4);
    endtask

    task automatic commit(input logic br, input logic nbr, input logic jmp, input logic jal,
                          input logic jrn, input logic zero, input logic [31:0] add,
                          input logic [31:0] rd1, input logic [31:0] exp_npc);
        Branch      = br;
        nBranch     = nbr;
        Jmp         = jmp;
        Jal         = jal;
        Jrn         = jrn;
        Zero        = zero;
        Add_result  = add;
        Read_data_1 = rd1;
        tick();
        {Branch, nBranch, Jmp, Jal, Jrn, Zero} = '0;
        Add_result  = 32'h0;
        Read_data_1 = 32'h0;
        check("npc.pc", PC, exp_npc);
        check("npc.valid", {31'b0, instr_valid}, 32'd0);
        check("npc.req", {31'b0, imem_req}, 32'd1);
    endtask

    logic [31:0] w_alu, w_beq, w_bne, w_jal, w_jr, w_j;

    initial begin
        w_alu = 32'h0022_1820;
        w_beq = {OpBeq, 5'd1, 5'd2, 16'h000B};
        w_bne = {OpBne, 5'd1, 5'd2, 16'h000B};
        w_jal = {OpJal, 26'h000_0100};
        w_jr  = {6'h00, 5'd31, 15'h0, FunctJr};
        w_j   = {OpJ, 26'h000_0200};

        reset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        stall = 1'b0;
        {Branch, nBranch, Jmp, Jal, Jrn, Zero} = '0;
        Add_result = 32'h0;
        Read_data_1 = 32'h0;

        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b1;
        check("idle.req", {31'b0, imem_req}, 32'd0);
        tick();

        // Zero-wait sequential fetch up to PC=0x10
        for (int i = 0; i < 4; i++) begin
            fetch(0, w_alu + i, 32'(i * 4));
            commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'(i * 4 + 4));
        end

        // Branches at 0x10 with Add_result=0x40
        fetch(0, w_beq, 32'h10);
        commit(1, 0, 0, 0, 0, 1, 32'h40, 32'h0, 32'h40);
        fetch(0, w_bne, 32'h40);
        commit(0, 1, 0, 0, 0, 0, 32'h10, 32'h0, 32'h10);
        fetch(0, w_beq, 32'h10);
        commit(1, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h14);
        fetch(0, w_jr, 32'h14);
        commit(0, 0, 0, 0, 1, 0, 32'h0, 32'h10, 32'h10);
        fetch(0, w_bne, 32'h10);
        commit(0, 1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h40);

        // Three wait states; misaligned jr target gets its low bits cleared
        fetch(3, w_jr, 32'h40);
        commit(0, 0, 0, 0, 1, 0, 32'h0, 32'h23, 32'h20);

        // jal then jr back, then Jrn beats Jmp
        fetch(0, w_jal, 32'h20);
        commit(0, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h400);
        check("jal.link", link_addr, 32'h24);
        fetch(1, w_jr, 32'h400);
        commit(0, 0, 0, 0, 1, 0, 32'h0, 32'h24, 32'h24);
        check("jr.link_hold", link_addr, 32'h24);
        fetch(0, w_j, 32'h24);
        commit(0, 0, 1, 0, 1, 0, 32'h0, 32'h30, 32'h30);

        // Stall five cycles in EXEC
        fetch(0, w_alu, 32'h30);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.valid", {31'b0, instr_valid}, 32'd1);
            check("stall.req", {31'b0, imem_req}, 32'd0);
            check("stall.pc", PC, 32'h30);
            check("stall.instr", Instruction, w_alu);
        end
        stall = 1'b0;
        commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h34);

        // PC wraps from 0xFFFF_FFFC to 0
        fetch(0, w_jr, 32'h34);
        commit(0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check("wrap.addr", {18'b0, imem_addr}, 32'h3FFF);
        check("wrap.pc4", PC_plus_4, 32'h0);
        fetch(0, w_alu, 32'hFFFF_FFFC);
        commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        fetch(0, w_alu, 32'h0);
        commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

        // Asynchronous reset during a FETCH wait, late ack ignored
        imem_ack = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("arst");
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("arst.instr_hold", Instruction, 32'h0);
        reset = 1'b1;
        tick();
        check("restart.instr", Instruction, 32'h0);
        check("restart.valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        fetch(0, w_beq, 32'h0);
        commit(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/minisys_ifetch.md
# minisys_ifetch

Instruction-fetch stage of the Minisys 32-bit single-issue core: holds the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and presents it to the control and decode stages. It sits directly upstream of the main control decoder and feeds it `Opcode` and `Function_opcode`. It consumes that decoder's `Branch`/`nBranch`/`Jmp`/`Jal`/`Jrn` outputs plus execute results to compute and commit the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `IMEM_AW`, default 14: instruction-memory word-address width (64 KiB).

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `imem_req` out 1: fetch request.
- `imem_addr` out IMEM_AW: word address, equal to `PC[IMEM_AW+1:2]`.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: hold the current instruction in EXEC.
- `Branch`, `nBranch`, `Jmp`, `Jal`, `Jrn` in 1 each: from control.
- `Zero` in 1: ALU equality flag.
- `Add_result` in 32: branch target from execute.
- `Read_data_1` in 32: rs value for `jr`.
- `Instruction` out 32: registered fetched word.
- `Opcode` out 6: `Instruction[31:26]`.
- `Function_opcode` out 6: `Instruction[5:0]`.
- `instr_valid` out 1: `Instruction` is executing this cycle.
- `PC` out 32: address of `Instruction`.
- `PC_plus_4` out 32: `PC + 4`.
- `link_addr` out 32: return address latched by `jal`.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- IDLE: entered only by reset. Goes to FETCH on the first clock after reset deassertion.
- FETCH: `imem_req`=1, `imem_addr` stable.
  - If `imem_ack`=1: `Instruction <= imem_rdata`, then go to EXEC.
  - Otherwise stay in FETCH with address unchanged.
- EXEC: `instr_valid`=1; control/execute evaluate combinationally.
  - If `stall`=1: stay in EXEC; PC and `Instruction` hold.
  - Otherwise commit `PC <= npc` and go to FETCH.
- `npc` selection, in priority order:
  - `Jrn`: `Read_data_1`.
  - `Jmp` or `Jal`: `{PC_plus_4[31:28], Instruction[25:0], 2'b00}`.
  - (`Branch` & `Zero`) or (`nBranch` & ~`Zero`): `Add_result`.
  - Otherwise: `PC_plus_4`.
- Bits [1:0] of `npc` are forced to 0 whenever it is loaded.
- On a committed `Jal`: `link_addr <= PC_plus_4`. `link_addr` is unchanged otherwise.
- Control inputs are ignored outside EXEC.
- `imem_ack` is ignored when `imem_req`=0.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `imem_addr` uses only `PC[IMEM_AW+1:2]`; upper PC bits are not checked.

## Timing
- Reset values:
  - PC = `RESET_PC`, state = IDLE.
  - `imem_req`=0, `instr_valid`=0.
  - `Instruction`=0, `link_addr`=0.
  - `Opcode`/`Function_opcode` = 0; `PC_plus_4` = `RESET_PC`+4.
- Reset is asynchronous at any point, including mid-FETCH with an ack pending. Outputs go to their reset values immediately; an outstanding request is abandoned.
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC. Each memory wait cycle adds 1.
- `Instruction` and PC update only on clock edges.
- `Opcode`, `Function_opcode`, `PC_plus_4` and `imem_addr` are combinational from registers.
- `npc` is combinational.
- First request: `imem_req` rises one cycle after reset deassertion, with `imem_addr` = `RESET_PC`>>2.

## Structure
- Shared package `minisys_pkg`: FSM state enum, opcode constants (J=6'h02, JAL=6'h03, BEQ=6'h04, BNE=6'h05), funct JR=6'h08, `RESET_PC` default.
- Sub-module `minisys_npc`: purely combinational next-PC mux. Inputs: PC_plus_4, Instruction[25:0], control bits, Zero, Add_result, Read_data_1. Output: npc.

## Test plan
- Zero-wait sequential fetch:
  - Stimulus: `RESET_PC`=0, ack in the same cycle as every req.
  - Response: `imem_addr` 0,1,2,3 on successive FETCHes; `instr_valid` high every other cycle.
- Wait states:
  - Stimulus: ack delayed 3 cycles.
  - Response: `imem_req` high 4 cycles with address stable; `Instruction` equals `imem_rdata` from the ack cycle.
- Branches at PC=0x10 with `Add_result`=0x40:
  - `Branch`=1, `Zero`=1: next address 0x40.
  - `Branch`=1, `Zero`=0: next address 0x14.
  - `nBranch`=1, `Zero`=0: next address 0x40.
- `jal` and `jr`:
  - `jal` 0x000_0100 at PC=0x20: `link_addr`=0x24, next PC=0x400.
  - Then `Jrn` with `Read_data_1`=0x24: next PC=0x24.
  - `Jrn`+`Jmp` together: `Jrn` wins.
- Stall: `stall`=1 for 5 cycles in EXEC → `instr_valid` held, PC and `Instruction` unchanged, `imem_req`=0; FETCH resumes the cycle after `stall` falls.
- Reset mid-fetch: assert `reset`=0 during a FETCH wait → outputs go to reset values immediately; a late `imem_ack` is ignored; fetch restarts at `RESET_PC`.
